// File: rtl/prog_sequencer.sv
// prog_sequencer: selects which of NUM_PROGS concatenated programs runs.
// A launch is a falling edge of init after a 2-flop synchroniser and one
// delay flop. Each launch advances prog_state, pulses pc_reset for one
// cycle and raises running until the matching done.
//
// Optional feature macro: PROG_SEQ_WRAP_EN
//   defined   : a launch after program NUM_PROGS wraps back to program 1.
//   undefined : done for program NUM_PROGS parks the FSM in HALT, and
//               every later launch is ignored until reset.
//
// dbg_state_o exposes the FSM state: 0=IDLE, 1=RUN, 2=WAIT, 3=HALT.
//
// Handshake: init is a level from an asynchronous source. It is sampled
// only through the synchroniser, so it has no valid/ready pairing. done is
// a single-cycle strobe that is accepted only in RUN and never stalled.
// All outputs are registered.
module prog_sequencer #(
  parameter int NUM_PROGS = 3,
  parameter int STATE_W   = $clog2(NUM_PROGS + 1)
) (
  input  logic               CLK,
  input  logic               reset_n,
  input  logic               init,
  input  logic               done,
  output logic [STATE_W-1:0] prog_state,
  output logic               pc_reset,
  output logic               running,
  output logic               all_done,
  output logic               overrun,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  // The increment is compared one bit wider than prog_state, so it cannot
  // wrap silently when NUM_PROGS+1 is a power of two.
  localparam logic [STATE_W:0]   LAST_EXT = (STATE_W + 1)'(NUM_PROGS);
  localparam logic [STATE_W-1:0] LAST     = STATE_W'(NUM_PROGS);

  state_t             state_q;
  logic [STATE_W-1:0] prog_q;
  logic [STATE_W-1:0] prog_d;
  logic [STATE_W:0]   prog_inc;
  logic               pc_reset_q;
  logic               running_q;
  logic               all_done_q;
  logic               overrun_q;
  logic               sync1_q;
  logic               init_s_q;
  logic               init_d_q;
  logic               launch;

  // These flops reset high. A low init present at reset release therefore
  // appears as a single falling edge and produces exactly one launch.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b1;
      init_s_q <= 1'b1;
      init_d_q <= 1'b1;
    end else begin
      sync1_q  <= init;
      init_s_q <= sync1_q;
      init_d_q <= init_s_q;
    end
  end

  assign launch = ~init_s_q & init_d_q;

  // Select the program number that the next launch loads.
  always_comb begin
    prog_inc = {1'b0, prog_q} + (STATE_W + 1)'(1);
    prog_d   = prog_inc[STATE_W-1:0];
    if (prog_inc > LAST_EXT) begin
`ifdef PROG_SEQ_WRAP_EN
      prog_d = STATE_W'(1);
`else
      prog_d = prog_q;
`endif
    end
  end

  // Sequencer FSM with registered status outputs. A launch wins over a done
  // that arrives in the same cycle.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      prog_q     <= '0;
      pc_reset_q <= 1'b0;
      running_q  <= 1'b0;
      all_done_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      pc_reset_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_RUN, ST_WAIT: begin
          if (launch) begin
            state_q    <= ST_RUN;
            prog_q     <= prog_d;
            pc_reset_q <= 1'b1;
            running_q  <= 1'b1;
            all_done_q <= 1'b0;
            if (state_q == ST_RUN) begin
              overrun_q <= 1'b1;
            end
          end else if ((state_q == ST_RUN) && done) begin
            running_q <= 1'b0;
            state_q   <= ST_WAIT;
            if (prog_q == LAST) begin
              all_done_q <= 1'b1;
`ifndef PROG_SEQ_WRAP_EN
              state_q    <= ST_HALT;
`endif
            end
          end
        end
        default: begin
          // HALT: launches and done pulses are ignored until reset.
        end
      endcase
    end
  end

  assign prog_state  = prog_q;
  assign pc_reset    = pc_reset_q;
  assign running     = running_q;
  assign all_done    = all_done_q;
  assign overrun     = overrun_q;
  assign dbg_state_o = state_q;

endmodule
